// File: rtl/pac_pkg.sv
// Shared encodings for the Pac-Man movement controller: directions,
// input-device key codes and the move FSM states.
package pac_pkg;

  typedef enum logic [1:0] {
    DIR_R = 2'd0,
    DIR_L = 2'd1,
    DIR_U = 2'd2,
    DIR_D = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ_PEND,
    REQ_CUR,
    WAIT_ACK
  } state_t;

  localparam logic [4:0] KP_UP    = 5'h01;
  localparam logic [4:0] KP_LEFT  = 5'h04;
  localparam logic [4:0] KP_DOWN  = 5'h05;
  localparam logic [4:0] KP_RIGHT = 5'h06;

  localparam logic [7:0] KB_UP_A    = 8'h1D;
  localparam logic [7:0] KB_UP_B    = 8'h75;
  localparam logic [7:0] KB_LEFT_A  = 8'h1C;
  localparam logic [7:0] KB_LEFT_B  = 8'h6B;
  localparam logic [7:0] KB_DOWN_A  = 8'h1B;
  localparam logic [7:0] KB_DOWN_B  = 8'h72;
  localparam logic [7:0] KB_RIGHT_A = 8'h23;
  localparam logic [7:0] KB_RIGHT_B = 8'h74;

  typedef struct packed {
    logic valid;
    dir_t dir;
  } dir_evt_t;

  function automatic dir_evt_t map_keypad(input logic [4:0] code);
    dir_evt_t e;
    e = '{valid: 1'b1, dir: DIR_R};
    case (code)
      KP_UP:    e.dir = DIR_U;
      KP_LEFT:  e.dir = DIR_L;
      KP_DOWN:  e.dir = DIR_D;
      KP_RIGHT: e.dir = DIR_R;
      default:  e.valid = 1'b0;
    endcase
    return e;
  endfunction

  function automatic dir_evt_t map_ps2(input logic [7:0] code);
    dir_evt_t e;
    e = '{valid: 1'b1, dir: DIR_R};
    case (code)
      KB_UP_A, KB_UP_B:       e.dir = DIR_U;
      KB_LEFT_A, KB_LEFT_B:   e.dir = DIR_L;
      KB_DOWN_A, KB_DOWN_B:   e.dir = DIR_D;
      KB_RIGHT_A, KB_RIGHT_B: e.dir = DIR_R;
      default:                e.valid = 1'b0;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/pac_tick_gen.sv
// Free-running move-tick generator: registered one-cycle pulse every
// TICK_CYCLES clocks; usable for any sprite that moves on a fixed cadence.
module pac_tick_gen #(
  parameter int TICK_CYCLES = 500000
) (
  input  logic clk,
  input  logic clrn,
  output logic tick
);

  localparam int CW = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

  logic [CW-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == LAST) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + 1'b1;
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/pac_move_ctrl.sv
// Pac-Man position controller: merges keypad/PS/2 turns into one pending
// turn and commits a move per tick after a wall-lookup handshake.
module pac_move_ctrl
  import pac_pkg::*;
#(
  parameter int X_INIT      = 30,
  parameter int Y_INIT      = 146,
  parameter int X_MIN       = 0,
  parameter int X_MAX       = 639,
  parameter int Y_MIN       = 0,
  parameter int Y_MAX       = 479,
  parameter int STEP        = 1,
  parameter int TICK_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       key_valid,
  input  logic [4:0] key_code,
  input  logic       kb_valid,
  input  logic [7:0] kb_code,
  output logic       wall_req,
  output logic [9:0] wall_x,
  output logic [8:0] wall_y,
  input  logic       wall_ack,
  input  logic       wall_hit,
  output logic [9:0] x,
  output logic [8:0] y,
  output logic [1:0] dir,
  output logic       moving
);

  state_t state, state_next;
  logic   tick;
  logic   key_q, kb_q;
  logic   pend_valid, try_pend, oor_q;
  dir_t   pend_dir, try_dir, dir_q, cur_try;
  dir_evt_t key_evt, kb_evt;
  logic   key_ev, kb_ev, oor, resolve, hit;
  logic signed [10:0] tx;
  logic signed [9:0]  ty;

  pac_tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
    .clk  (clk),
    .clrn (clrn),
    .tick (tick)
  );

  assign key_evt = map_keypad(key_code);
  assign kb_evt  = map_ps2(kb_code);
  assign key_ev  = key_valid & ~key_q & key_evt.valid;
  assign kb_ev   = kb_valid & ~kb_q & kb_evt.valid;
  // An out-of-range target never issues a request and resolves as a hit.
  assign resolve = oor_q | wall_ack;
  assign hit     = oor_q | wall_hit;
  assign dir     = dir_q;

  always_comb begin
    cur_try = (state == REQ_PEND) ? pend_dir : dir_q;
    tx = signed'({1'b0, x});
    ty = signed'({1'b0, y});
    case (cur_try)
      DIR_R: tx = tx + 11'(STEP);
      DIR_L: tx = tx - 11'(STEP);
      DIR_U: ty = ty - 10'(STEP);
      DIR_D: ty = ty + 10'(STEP);
    endcase
    oor = (tx < 11'(X_MIN)) || (tx > 11'(X_MAX)) ||
          (ty < 10'(Y_MIN)) || (ty > 10'(Y_MAX));
  end

  always_ff @(posedge clk) begin
    if (!clrn) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:              if (tick) state_next = pend_valid ? REQ_PEND : REQ_CUR;
      REQ_PEND, REQ_CUR: state_next = WAIT_ACK;
      WAIT_ACK:          if (resolve) state_next = (hit && try_pend) ? REQ_CUR : IDLE;
      default:           state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      key_q      <= 1'b0;
      kb_q       <= 1'b0;
      pend_valid <= 1'b0;
      pend_dir   <= DIR_R;
      try_dir    <= DIR_R;
      try_pend   <= 1'b0;
      oor_q      <= 1'b0;
      wall_req   <= 1'b0;
      wall_x     <= '0;
      wall_y     <= '0;
      x          <= 10'(X_INIT);
      y          <= 9'(Y_INIT);
      dir_q      <= DIR_R;
      moving     <= 1'b0;
    end else begin
      key_q <= key_valid;
      kb_q  <= kb_valid;
      case (state)
        REQ_PEND, REQ_CUR: begin
          try_dir  <= cur_try;
          try_pend <= (state == REQ_PEND);
          wall_x   <= tx[9:0];
          wall_y   <= ty[8:0];
          wall_req <= ~oor;
          oor_q    <= oor;
        end
        WAIT_ACK: if (resolve) begin
          wall_req <= 1'b0;
          oor_q    <= 1'b0;
          if (!hit) begin
            x      <= wall_x;
            y      <= wall_y;
            dir_q  <= try_dir;
            moving <= 1'b1;
            if (try_pend) pend_valid <= 1'b0;
          end else if (!try_pend) begin
            moving <= 1'b0;
          end
        end
        default: ;
      endcase
      // A fresh event lands after the clear so it is never lost.
      if (key_ev) begin
        pend_valid <= 1'b1;
        pend_dir   <= key_evt.dir;
      end else if (kb_ev) begin
        pend_valid <= 1'b1;
        pend_dir   <= kb_evt.dir;
      end
    end
  end

endmodule

// File: tb/tb_pac_move_ctrl.sv
// Self-checking bench for pac_move_ctrl: table-driven single moves with a
// scoreboard queue, plus hand-written handshake and reset corner cases.
module tb_pac_move_ctrl;

  localparam int TICK = 16;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic       key_valid = 1'b0, kb_valid = 1'b0;
  logic [4:0] key_code = '0;
  logic [7:0] kb_code = '0;
  logic       wall_ack = 1'b0, wall_hit = 1'b0;
  logic       wall_req, moving;
  logic [9:0] wall_x, x;
  logic [8:0] wall_y, y;
  logic [1:0] dir;

  logic       key2_valid = 1'b0;
  logic [4:0] key2_code = '0;
  logic       wall2_ack = 1'b0;
  logic       wall2_req, moving2;
  logic [9:0] wall2_x, x2;
  logic [8:0] wall2_y, y2;
  logic [1:0] dir2;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pac_move_ctrl #(.TICK_CYCLES(TICK)) u_dut (
    .clk(clk), .clrn(clrn),
    .key_valid(key_valid), .key_code(key_code),
    .kb_valid(kb_valid), .kb_code(kb_code),
    .wall_req(wall_req), .wall_x(wall_x), .wall_y(wall_y),
    .wall_ack(wall_ack), .wall_hit(wall_hit),
    .x(x), .y(y), .dir(dir), .moving(moving)
  );

  pac_move_ctrl #(.X_INIT(31), .X_MIN(30), .TICK_CYCLES(TICK)) u_dut2 (
    .clk(clk), .clrn(clrn),
    .key_valid(key2_valid), .key_code(key2_code),
    .kb_valid(1'b0), .kb_code(8'h00),
    .wall_req(wall2_req), .wall_x(wall2_x), .wall_y(wall2_y),
    .wall_ack(wall2_ack), .wall_hit(1'b0),
    .x(x2), .y(y2), .dir(dir2), .moving(moving2)
  );

  typedef struct {
    bit         kb;
    logic [7:0] code;
    bit         hit;
    logic [9:0] tx;
    logic [8:0] ty;
    logic [1:0] edir;
  } vec_t;

  typedef struct {
    logic [9:0] x;
    logic [8:0] y;
    logic [1:0] dir;
    logic       moving;
  } exp_t;

  vec_t vecs[14];
  exp_t sb[$];

  function automatic vec_t mk(bit kb, logic [7:0] code, bit hit,
                              int tx, int ty, int edir);
    vec_t v;
    v.kb = kb; v.code = code; v.hit = hit;
    v.tx = 10'(tx); v.ty = 9'(ty); v.edir = 2'(edir);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    clrn = 1'b0;
    key_valid = 1'b0; kb_valid = 1'b0; key2_valid = 1'b0;
    wall_ack = 1'b0; wall_hit = 1'b0; wall2_ack = 1'b0;
    repeat (2) @(negedge clk);
    clrn = 1'b1;
  endtask

  task automatic wait_req(input string name);
    for (int i = 0; i < 64 && !wall_req; i++) @(negedge clk);
    check(name, wall_req, 1);
  endtask

  task automatic pulse_ack(input logic hit);
    @(negedge clk);
    wall_hit = hit; wall_ack = 1'b1;
    @(negedge clk);
    wall_hit = 1'b0; wall_ack = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    exp_t e;
    int   n;
    bit   seen;

    // Start x=30 y=146 dir=right for every vector.
    vecs[0]  = mk(0, 8'h01, 0, 30, 145, 2);
    vecs[1]  = mk(0, 8'h04, 0, 29, 146, 1);
    vecs[2]  = mk(0, 8'h05, 0, 30, 147, 3);
    vecs[3]  = mk(0, 8'h06, 0, 31, 146, 0);
    vecs[4]  = mk(1, 8'h1D, 0, 30, 145, 2);
    vecs[5]  = mk(1, 8'h75, 0, 30, 145, 2);
    vecs[6]  = mk(1, 8'h1C, 0, 29, 146, 1);
    vecs[7]  = mk(1, 8'h6B, 0, 29, 146, 1);
    vecs[8]  = mk(1, 8'h1B, 0, 30, 147, 3);
    vecs[9]  = mk(1, 8'h72, 0, 30, 147, 3);
    vecs[10] = mk(1, 8'h23, 0, 31, 146, 0);
    vecs[11] = mk(1, 8'h74, 0, 31, 146, 0);
    vecs[12] = mk(0, 8'h02, 1, 31, 146, 0);
    vecs[13] = mk(1, 8'h55, 0, 31, 146, 0);

    // Reset values and first-tick latency.
    @(negedge clk);
    clrn = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_x", x, 30);
    check("rst_y", y, 146);
    check("rst_dir", dir, 0);
    check("rst_moving", moving, 0);
    check("rst_wall_req", wall_req, 0);
    clrn = 1'b1;
    n = 0;
    for (int i = 0; i < 64 && !wall_req; i++) begin
      @(negedge clk);
      n++;
    end
    check("first_req_cycle", n, TICK + 2);

    // Table-driven single moves.
    foreach (vecs[i]) begin
      do_reset();
      @(negedge clk);
      if (vecs[i].kb) begin kb_code = vecs[i].code; kb_valid = 1'b1; end
      else begin key_code = vecs[i].code[4:0]; key_valid = 1'b1; end
      if (vecs[i].hit) e = '{x: 10'd30, y: 9'd146, dir: 2'd0, moving: 1'b0};
      else e = '{x: vecs[i].tx, y: vecs[i].ty, dir: vecs[i].edir, moving: 1'b1};
      sb.push_back(e);
      @(negedge clk);
      key_valid = 1'b0; kb_valid = 1'b0;
      wait_req($sformatf("v%0d_req", i));
      check($sformatf("v%0d_wall_x", i), wall_x, vecs[i].tx);
      check($sformatf("v%0d_wall_y", i), wall_y, vecs[i].ty);
      pulse_ack(vecs[i].hit);
      e = sb.pop_front();
      check($sformatf("v%0d_x", i), x, e.x);
      check($sformatf("v%0d_y", i), y, e.y);
      check($sformatf("v%0d_dir", i), dir, e.dir);
      check($sformatf("v%0d_moving", i), moving, e.moving);
      check($sformatf("v%0d_req_drop", i), wall_req, 0);
      check($sformatf("v%0d_pend", i), u_dut.pend_valid, 0);
    end

    // Pending up blocked, current right retried and accepted.
    do_reset();
    @(negedge clk);
    key_code = 5'h01; key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    check("retry_pend_set", u_dut.pend_valid, 1);
    wait_req("retry_req1");
    check("retry_wall_y1", wall_y, 145);
    pulse_ack(1'b1);
    check("retry_req_gap", wall_req, 0);
    @(negedge clk);
    check("retry_req2", wall_req, 1);
    check("retry_wall_x2", wall_x, 31);
    check("retry_wall_y2", wall_y, 146);
    pulse_ack(1'b0);
    check("retry_x", x, 31);
    check("retry_y", y, 146);
    check("retry_dir", dir, 0);
    check("retry_pend_kept", u_dut.pend_valid, 1);

    // Same-cycle keypad left and PS/2 right: keypad wins.
    do_reset();
    @(negedge clk);
    key_code = 5'h04; key_valid = 1'b1;
    kb_code = 8'h23; kb_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0; kb_valid = 1'b0;
    wait_req("arb_req");
    check("arb_wall_x", wall_x, 29);
    pulse_ack(1'b0);
    check("arb_x", x, 29);
    check("arb_dir", dir, 1);

    // Reset mid-handshake, then a stray ack in IDLE.
    do_reset();
    wait_req("rst_hs_req");
    do_reset();
    pulse_ack(1'b0);
    @(negedge clk);
    check("rst_hs_wall_req", wall_req, 0);
    check("rst_hs_x", x, 30);
    check("rst_hs_y", y, 146);
    check("rst_hs_moving", moving, 0);

    // X_MIN boundary on the second instance: move left to 30, then stall.
    do_reset();
    @(negedge clk);
    key2_code = 5'h04; key2_valid = 1'b1;
    @(negedge clk);
    key2_valid = 1'b0;
    for (int i = 0; i < 64 && !wall2_req; i++) @(negedge clk);
    check("min_req", wall2_req, 1);
    check("min_wall_x", wall2_x, 30);
    @(negedge clk);
    wall2_ack = 1'b1;
    @(negedge clk);
    wall2_ack = 1'b0;
    check("min_x1", x2, 30);
    check("min_dir1", dir2, 1);
    check("min_moving1", moving2, 1);
    seen = 1'b0;
    for (int i = 0; i < 3 * TICK; i++) begin
      @(negedge clk);
      if (wall2_req) seen = 1'b1;
    end
    check("min_no_req", seen, 0);
    check("min_moving2", moving2, 0);
    check("min_x2", x2, 30);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/pac_move_ctrl.md
# pac_move_ctrl

Sequencing controller for the Pac-Man sprite position register. It merges direction events from the on-board keypad and the PS/2 keyboard and buffers one pending turn. On each move tick it asks the maze-wall lookup whether the target cell is free through a req/ack handshake, then commits the new X/Y and facing direction. It sits between the input decoders and the display/seven-segment consumers, replacing ad-hoc position updates at top level.

## Interface
Parameters:
- X_INIT, 30, X after reset
- Y_INIT, 146, Y after reset
- X_MIN / X_MAX, 0 / 639, legal X range (inclusive)
- Y_MIN / Y_MAX, 0 / 479, legal Y range (inclusive)
- STEP, 1, pixels moved per accepted tick
- TICK_CYCLES, 500000, clk cycles per move tick (2..2^24)

Ports:
- clk  in  1  system clock; all logic on posedge
- clrn  in  1  reset; synchronous, active-low
- key_valid  in  1  keypad ready (level; rising edge = event)
- key_code  in  5  keypad code
- kb_valid  in  1  PS/2 ready (level; rising edge = event)
- kb_code  in  8  PS/2 scan code, low byte
- wall_req  out  1  wall lookup request
- wall_x  out  10  target X; stable while wall_req=1
- wall_y  out  9  target Y; stable while wall_req=1
- wall_ack  in  1  lookup done; one-cycle pulse
- wall_hit  in  1  target blocked; valid with wall_ack
- x  out  10  Pac-Man X
- y  out  9  Pac-Man Y
- dir  out  2  facing: 0 right, 1 left, 2 up, 3 down
- moving  out  1  last tick produced a move

## Operation
- Event capture: a rising edge of key_valid or kb_valid is an event. Unmapped codes are ignored.
  - Keypad mapping: 5'h01 up, 5'h04 left, 5'h05 down, 5'h06 right.
  - PS/2 mapping: 1D/75 up, 1C/6B left, 1B/72 down, 23/74 right.
- Arbitration: keypad and PS/2 events in the same cycle → keypad wins; the PS/2 event is discarded.
- Pending turn: an accepted event writes pend_dir and sets pend_valid, overwriting any earlier pending turn. Events are accepted in every FSM state.
- Tick generator: free-running counter over 0..TICK_CYCLES-1; it emits a one-cycle tick at the wrap. A tick that arrives while the FSM is not in IDLE is dropped. The counter never stalls.
- FSM states: IDLE, REQ_PEND, REQ_CUR, WAIT_ACK.
  - IDLE + tick → REQ_PEND if pend_valid, else REQ_CUR.
  - REQ_PEND / REQ_CUR: latch try_dir, compute the target, go to WAIT_ACK with wall_req=1.
  - Out-of-range target: treat as hit with no request, resolved in the next cycle.
  - WAIT_ACK + wall_ack, hit=0: x/y ← target, dir ← try_dir, moving ← 1. If try_dir came from pending, clear pend_valid. → IDLE.
  - WAIT_ACK + wall_ack, hit=1 on a pending try: keep pend_valid (retry next tick) → REQ_CUR.
  - WAIT_ACK + wall_ack, hit=1 on a current try: moving ← 0 → IDLE.
  - No timeout: WAIT_ACK holds until wall_ack.
- Arithmetic: the target is computed in 11-bit (X) and 10-bit (Y) signed space so underflow is detectable. Target < MIN or > MAX counts as out of range.
- A pending turn overwritten during WAIT_ACK does not affect the in-flight try_dir.
- Reset values (clrn=0 at a posedge): x=X_INIT, y=Y_INIT, dir=0, moving=0, wall_req=0, pend_valid=0, tick counter=0, FSM=IDLE, edge-detect registers=0. Reset mid-handshake abandons the request; a later stray wall_ack in IDLE is ignored.

## Timing
- Tick in cycle T → wall_req=1 at T+2 (REQ_* in T+1, WAIT_ACK registered).
- wall_ack sampled in cycle A → wall_req=0 and x/y/dir/moving updated in A+1.
- Pending try blocked at A → second wall_req at A+2.
- Event edge in cycle E → pend_valid=1 in E+1.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package pac_pkg holds:
  - dir encoding constants (DIR_R/L/U/D)
  - keypad and PS/2 code constants
  - FSM state encoding
- Sub-module pac_tick_gen (parameter TICK_CYCLES; ports clk, clrn, tick). It is reusable for ghost movement.

## Test plan
- Reset: hold clrn=0 two cycles → x=30, y=146, dir=0, moving=0, wall_req=0; after release the first tick comes at cycle TICK_CYCLES.
- Keypad 5'h01 edge, tick, ack hit=0 → y=145, dir=2, moving=1, pend_valid=0 one cycle after ack.
- Pending up blocked (hit=1), current right free → second request carries wall_x=31, wall_y=146; final x=31, dir=0, pend_valid still 1.
- Keypad 5'h04 and PS/2 8'h23 edges in the same cycle, tick, ack hit=0 → x=29, dir=1.
- X_MIN=30, dir left, tick → no wall_req; moving=0; x stays 30.
- clrn=0 during WAIT_ACK, then wall_ack pulse in IDLE → wall_req=0, x/y stay at reset values, no move.
